simproc: RTL and testbench

- Multi-cycle 8-bit processor with four 8-bit general registers, an 8-bit program counter and a single combinational-read data/instruction memory port.
- Each `run` pulse executes exactly one instruction (single-step) and ends with a one-cycle `done` pulse.
- The host preloads the PC via `pc_set_wr`/`pc_set_val`.
- A STOP instruction asserts a sticky `halt`.

---
 rtl/simproc.sv | 218 +++++++++++++++++++++
 tb/tb_simproc.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simproc.sv
// simproc: multi-cycle 8-bit single-step processor, 4 registers, one shared memory port.
// Build option SIMPROC_AUTORUN_EN: after DONE keep fetching until STOP instead of idling.

module simproc_rf (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [1:0] wa,
    input  logic [7:0] wd,
    input  logic [1:0] ra_a,
    input  logic [1:0] ra_b,
    output logic [7:0] rd_a,
    output logic [7:0] rd_b
);
    logic [7:0] rf [0:3];

    // NOTE: rf is four plain flip-flop words rather than a RAM, so it carries a reset like any other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else if (we) begin
            rf[wa] <= wd;
        end
    end

    assign rd_a = rf[ra_a];
    assign rd_b = rf[ra_b];
endmodule

module simproc (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] pc_set_val,
    input  logic       pc_set_wr,
    input  logic [7:0] mem_dout,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_din,
    output logic       mem_we,
    output logic       halt,
    output logic       done
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STOP  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_SHL   = 4'b0011;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_SHR   = 4'b1011;
    localparam logic [3:0] OP_BPZ   = 4'b1101;

    state_t     curr_state;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic       flag_z;
    logic       flag_n;

    logic       is_ori;
    logic       is_load;
    logic       is_store;
    logic       is_stop;
    logic [7:0] alu_res;
    logic       alu_wr;
    logic       br_taken;
    logic [7:0] br_target;

    logic       rf_we;
    logic [1:0] rf_wa;
    logic [7:0] rf_wd;
    logic [1:0] rf_ra_a;
    logic [7:0] rf_rd_a;
    logic [7:0] rf_rd_b;

    // ORI owns every code ending in 111, so it is decoded ahead of the 4-bit opcodes.
    assign is_ori   = (ir[2:0] == 3'b111);
    assign is_load  = (ir[3:0] == OP_LOAD);
    assign is_store = (ir[3:0] == OP_STORE);
    assign is_stop  = (ir[3:0] == OP_STOP);

    // NOTE: combinational blocks assign every output a default first, so no latch can be inferred.
    always_comb begin
        alu_res = '0;
        alu_wr  = 1'b0;
        if (is_ori) begin
            alu_res = a_reg | {3'b000, ir[7:3]};
            alu_wr  = 1'b1;
        end else begin
            case (ir[3:0])
                OP_ADD:  begin alu_res = a_reg + b_reg;       alu_wr = 1'b1; end
                OP_SUB:  begin alu_res = a_reg - b_reg;       alu_wr = 1'b1; end
                OP_NAND: begin alu_res = ~(a_reg & b_reg);    alu_wr = 1'b1; end
                OP_SHL:  begin alu_res = a_reg << b_reg[2:0]; alu_wr = 1'b1; end
                OP_SHR:  begin alu_res = a_reg >> b_reg[2:0]; alu_wr = 1'b1; end
                default: ;
            endcase
        end
    end

    always_comb begin
        br_taken = 1'b0;
        case (ir[3:0])
            OP_BZ:   br_taken = flag_z;
            OP_BNZ:  br_taken = ~flag_z;
            OP_BPZ:  br_taken = ~flag_n;
            default: br_taken = 1'b0;
        endcase
    end

    // PC has already advanced past the branch when the offset is applied.
    assign br_target = pc + {{4{ir[7]}}, ir[7:4]};

    assign rf_ra_a = is_ori ? 2'd1 : ir[7:6];
    assign rf_wa   = is_ori ? 2'd1 : ir[7:6];
    assign rf_we   = ((curr_state == EXEC) && alu_wr) || ((curr_state == MEM) && is_load);
    assign rf_wd   = (curr_state == MEM) ? mem_dout : alu_res;

    simproc_rf RF1 (
        .clk  (clk),
        .rst  (rst),
        .we   (rf_we),
        .wa   (rf_wa),
        .wd   (rf_wd),
        .ra_a (rf_ra_a),
        .ra_b (ir[5:4]),
        .rd_a (rf_rd_a),
        .rd_b (rf_rd_b)
    );

    always_comb begin
        mem_addr = pc;
        mem_din  = '0;
        mem_we   = 1'b0;
        if (curr_state == MEM) begin
            mem_addr = b_reg;
            if (is_store) begin
                mem_din = a_reg;
                mem_we  = 1'b1;
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            curr_state <= IDLE;
            pc         <= '0;
            ir         <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            flag_z     <= 1'b0;
            flag_n     <= 1'b0;
            halt       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (curr_state)
                IDLE: begin
                    if (pc_set_wr) begin
                        pc   <= pc_set_val;
                        halt <= 1'b0;
                    end else if (run && !halt) begin
                        curr_state <= FETCH;
                    end
                end
                FETCH: begin
                    ir         <= mem_dout;
                    pc         <= pc + 8'd1;
                    curr_state <= DECODE;
                end
                DECODE: begin
                    a_reg      <= rf_rd_a;
                    b_reg      <= rf_rd_b;
                    curr_state <= EXEC;
                end
                EXEC: begin
                    if (alu_wr) begin
                        flag_z <= (alu_res == 8'd0);
                        flag_n <= alu_res[7];
                    end
                    if (!is_ori && br_taken) pc <= br_target;
                    if (!is_ori && is_stop) halt <= 1'b1;
                    if (!is_ori && (is_load || is_store)) begin
                        curr_state <= MEM;
                    end else begin
                        curr_state <= DONE;
                        done       <= 1'b1;
                    end
                end
                MEM: begin
                    curr_state <= DONE;
                    done       <= 1'b1;
                end
                DONE: begin
`ifdef SIMPROC_AUTORUN_EN
                    curr_state <= halt ? IDLE : FETCH;
`else
                    curr_state <= IDLE;
`endif
                end
                default: curr_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_simproc.sv
// Bench for simproc: table of single-step instructions checked through a scoreboard,
// plus hand-written halt, PC-load and reset-abort sequences.
module tb_simproc;
    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       pc_set_wr;
    logic [7:0] pc_set_val;
    logic [7:0] mem_dout;
    logic [7:0] mem_addr;
    logic [7:0] mem_din;
    logic       mem_we;
    logic       halt;
    logic       done;

    simproc dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .pc_set_val (pc_set_val),
        .pc_set_wr  (pc_set_wr),
        .mem_dout   (mem_dout),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .halt       (halt),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read, clocked write from the DUT or from the host poke port.
    logic [7:0] mem [0:255];
    logic       host_we   = 1'b0;
    logic [7:0] host_addr = '0;
    logic [7:0] host_data = '0;
    assign mem_dout = mem[mem_addr];
    always @(posedge clk) begin
        if (host_we) mem[host_addr] <= host_data;
        else if (mem_we === 1'b1) mem[mem_addr] <= mem_din;
    end

    logic       mon_en    = 1'b0;
    int         we_cycles = 0;
    int         din_leaks = 0;
    logic [7:0] we_addr   = '0;
    logic [7:0] we_data   = '0;
    always @(posedge clk) begin
        if (mon_en && mem_we === 1'b1) begin
            we_cycles <= we_cycles + 1;
            we_addr   <= mem_addr;
            we_data   <= mem_din;
        end
    end
    always @(negedge clk) begin
        if (mon_en && mem_we !== 1'b1 && mem_din !== 8'h00) din_leaks <= din_leaks + 1;
    end

    typedef struct packed {
        logic       set_pc;
        logic [7:0] pc;
        logic [7:0] ir;
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] r3;
        logic [7:0] pc_after;
        logic [3:0] lat;
        logic       z;
        logic       hlt;
    } vec_t;

    vec_t vtab [$];
    vec_t sb_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic add(input logic s, input logic [7:0] pc, input logic [7:0] ir,
                       input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                       input logic [7:0] r3, input logic [7:0] pa, input logic [3:0] lat,
                       input logic z, input logic h);
        vtab.push_back('{s, pc, ir, r0, r1, r2, r3, pa, lat, z, h});
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        host_we = 1'b1; host_addr = a; host_data = d;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic pc_load(input logic [7:0] v);
        @(negedge clk);
        pc_set_wr = 1'b1; pc_set_val = v;
        @(negedge clk);
        pc_set_wr = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        vec_t       exp;
        int         lat;
        logic [7:0] fetch_addr;
        if (v.set_pc) pc_load(v.pc);
        poke(v.pc, v.ir);
        sb_q.push_back(v);
        @(negedge clk); run = 1'b1;
        @(posedge clk); lat = 1;
        @(negedge clk); run = 1'b0; fetch_addr = mem_addr;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        exp = sb_q.pop_front();
        check($sformatf("v%0d fetch_addr", idx), fetch_addr, exp.pc);
        check($sformatf("v%0d done", idx), done, 1'b1);
        check($sformatf("v%0d latency", idx), lat, exp.lat);
        check($sformatf("v%0d pc", idx), mem_addr, exp.pc_after);
        check($sformatf("v%0d r0", idx), dut.RF1.rf[0], exp.r0);
        check($sformatf("v%0d r1", idx), dut.RF1.rf[1], exp.r1);
        check($sformatf("v%0d r2", idx), dut.RF1.rf[2], exp.r2);
        check($sformatf("v%0d r3", idx), dut.RF1.rf[3], exp.r3);
        check($sformatf("v%0d z", idx), dut.flag_z, exp.z);
        check($sformatf("v%0d halt", idx), halt, exp.hlt);
        @(negedge clk);
        check($sformatf("v%0d done_pulse", idx), done, 1'b0);
        check($sformatf("v%0d back_idle", idx), dut.curr_state, 3'd0);
    endtask

    initial begin
        int n;
        int seen;

        //  set pc  ir    r0    r1    r2    r3    pc'   lat z  halt
        add(1, 8'h3C, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3D, 4, 0, 0); // NOP at loaded PC
        add(1, 8'h40, 8'hE7, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h41, 4, 0, 0); // ORI 1C
        add(0, 8'h41, 8'h10, 8'h12, 8'h1C, 8'h00, 8'h00, 8'h42, 5, 0, 0); // LOAD R0,[R1]
        add(0, 8'h42, 8'h0F, 8'h12, 8'h1D, 8'h00, 8'h00, 8'h43, 4, 0, 0); // ORI 01
        add(0, 8'h43, 8'h50, 8'h12, 8'h34, 8'h00, 8'h00, 8'h44, 5, 0, 0); // LOAD R1,[R1]
        add(1, 8'h00, 8'h44, 8'h12, 8'h46, 8'h00, 8'h00, 8'h01, 4, 0, 0); // ADD R1,R0
        add(1, 8'h44, 8'h06, 8'h00, 8'h46, 8'h00, 8'h00, 8'h45, 4, 1, 0); // SUB R0,R0
        add(1, 8'h01, 8'h47, 8'h00, 8'h4E, 8'h00, 8'h00, 8'h02, 4, 0, 0); // ORI 08
        add(0, 8'h02, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03, 4, 1, 0); // SUB R1,R1
        add(0, 8'h03, 8'hF7, 8'h00, 8'h1E, 8'h00, 8'h00, 8'h04, 4, 0, 0); // ORI 1E
        add(0, 8'h04, 8'h10, 8'hAA, 8'h1E, 8'h00, 8'h00, 8'h05, 5, 0, 0); // LOAD R0,[R1]
        add(0, 8'h05, 8'h0F, 8'hAA, 8'h1F, 8'h00, 8'h00, 8'h06, 4, 0, 0); // ORI 01
        add(0, 8'h06, 8'hD0, 8'hAA, 8'h1F, 8'h00, 8'h80, 8'h07, 5, 0, 0); // LOAD R3,[R1]
        add(0, 8'h07, 8'h32, 8'hAA, 8'h1F, 8'h00, 8'h80, 8'h08, 5, 0, 0); // STORE [R3],R0
        add(0, 8'h08, 8'h70, 8'hAA, 8'hAA, 8'h00, 8'h80, 8'h09, 5, 0, 0); // LOAD R1,[R3]
        add(0, 8'h09, 8'h88, 8'hAA, 8'hAA, 8'hFF, 8'h80, 8'h0A, 4, 0, 0); // NAND R2,R0
        add(0, 8'h0A, 8'h9B, 8'hAA, 8'hAA, 8'h3F, 8'h80, 8'h0B, 4, 0, 0); // SHR R2,R1
        add(0, 8'h0B, 8'h13, 8'hA8, 8'hAA, 8'h3F, 8'h80, 8'h0C, 4, 0, 0); // SHL R0,R1
        add(0, 8'h0C, 8'h3D, 8'hA8, 8'hAA, 8'h3F, 8'h80, 8'h0D, 4, 0, 0); // BPZ +3, N=1
        add(0, 8'h0D, 8'h0A, 8'hA8, 8'hAA, 8'h3F, 8'h80, 8'h0E, 4, 0, 0); // NOP
        add(0, 8'h0E, 8'h06, 8'h00, 8'hAA, 8'h3F, 8'h80, 8'h0F, 4, 1, 0); // SUB R0,R0
        add(0, 8'h0F, 8'hE5, 8'h00, 8'hAA, 8'h3F, 8'h80, 8'h0E, 4, 1, 0); // BZ -2 taken
        add(1, 8'h20, 8'h79, 8'h00, 8'hAA, 8'h3F, 8'h80, 8'h21, 4, 1, 0); // BNZ, Z=1
        add(0, 8'h21, 8'h2D, 8'h00, 8'hAA, 8'h3F, 8'h80, 8'h24, 4, 1, 0); // BPZ +2 taken
        add(1, 8'hFF, 8'h0A, 8'h00, 8'hAA, 8'h3F, 8'h80, 8'h00, 4, 1, 0); // PC wrap
        add(1, 8'h30, 8'h01, 8'h00, 8'hAA, 8'h3F, 8'h80, 8'h31, 4, 1, 1); // STOP

        // Reset with a competing PC load: reset must win.
        rst = 1'b1; run = 1'b0; pc_set_wr = 1'b1; pc_set_val = 8'h77;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst pc", mem_addr, 8'h00);
        check("rst halt", halt, 1'b0);
        check("rst done", done, 1'b0);
        check("rst state", dut.curr_state, 3'd0);
        check("rst z", dut.flag_z, 1'b0);
        for (int i = 0; i < 4; i++) check($sformatf("rst rf%0d", i), dut.RF1.rf[i], 8'h00);
        rst = 1'b0; pc_set_wr = 1'b0;
        mon_en = 1'b1;

        poke(8'h1C, 8'h12);
        poke(8'h1D, 8'h34);
        poke(8'h1E, 8'hAA);
        poke(8'h1F, 8'h80);

        pc_load(8'h3C);
        check("pc load idle", mem_addr, 8'h3C);

        for (int i = 0; i < vtab.size(); i++) run_vec(i, vtab[i]);

        check("store we cycles", we_cycles, 1);
        check("store addr", we_addr, 8'h80);
        check("store data", we_data, 8'hAA);
        check("store mem80", mem[8'h80], 8'hAA);

        // Halted: run must be ignored.
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("halted no done", seen, 0);
        check("halted state", dut.curr_state, 3'd0);
        check("halted pc", mem_addr, 8'h31);
        check("halted halt", halt, 1'b1);

        // PC load clears halt.
        pc_load(8'h50);
        check("pcset clears halt", halt, 1'b0);
        check("pcset pc", mem_addr, 8'h50);

        // Reset in the middle of a store: nothing may reach memory or registers.
        poke(8'h50, 8'h32);
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        n = 0;
        while (dut.curr_state !== 3'd3 && n < 10) begin
            @(negedge clk); n++;
        end
        check("abort reached exec", dut.curr_state, 3'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort state", dut.curr_state, 3'd0);
        check("abort pc", mem_addr, 8'h00);
        check("abort done", done, 1'b0);
        for (int i = 0; i < 4; i++) check($sformatf("abort rf%0d", i), dut.RF1.rf[i], 8'h00);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("abort no done", seen, 0);
        check("abort no store", we_cycles, 1);
        check("abort mem80", mem[8'h80], 8'hAA);
        check("mem_din idle zero", din_leaks, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
